// File: rtl/alu_result_buffer.sv
// alu_result_buffer: first-word-fall-through FIFO that sits directly behind
// the ALU. The ALU cannot be stalled, so results that find no free slot are
// dropped and recorded in a sticky overflow flag. Every ALU strobe advances a
// sequence tag, including strobes that are dropped, so gaps in the tag
// sequence reveal where results were lost.
// Optional feature: define ALU_RESULT_PARITY_EN to store an even-parity bit
// per entry and expose it on out_parity.
module alu_result_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_alu,
    input  logic                       in_carry,
    input  logic                       in_zero,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_alu,
    output logic                       out_carry,
    output logic                       out_zero,
    output logic [TAG_W-1:0]           out_tag,
`ifdef ALU_RESULT_PARITY_EN
    output logic                       out_parity,
`endif
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic              carry;
        logic              zero;
        logic [TAG_W-1:0]  tag;
`ifdef ALU_RESULT_PARITY_EN
        logic              parity;
`endif
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          wr_entry;
    entry_t          head;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic [TAG_W-1:0] tag_q,   tag_d;
    logic            ovf_q,    ovf_d;

    logic            push, pop, drop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees a slot in the same cycle, so a full buffer still accepts a
    // result when the consumer is draining. Pop needs a real head entry, so
    // out_ready on an empty buffer does nothing.
    assign pop  = !empty && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    // Build the entry written at the tail; tag is the pre-increment value.
    always_comb begin
        wr_entry        = '0;
        wr_entry.alu    = in_alu;
        wr_entry.carry  = in_carry;
        wr_entry.zero   = in_zero;
        wr_entry.tag    = tag_q;
`ifdef ALU_RESULT_PARITY_EN
        wr_entry.parity = ^{in_alu, in_carry, in_zero};
`endif
    end

    // Next-state for pointers, occupancy, tag counter and sticky overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tag_d    = tag_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (in_valid) tag_d = tag_q + 1'b1;
        // A drop in the same cycle as a clear keeps the flag set.
        if (drop)         ovf_d = 1'b1;
        else if (clr_ovf) ovf_d = 1'b0;
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[wr_ptr_q] <= wr_entry;
    end

    // Head entry falls through to the outputs; it only changes on a pop.
    assign head      = mem_q[rd_ptr_q];
    assign out_valid = !empty;
    assign out_alu   = head.alu;
    assign out_carry = head.carry;
    assign out_zero  = head.zero;
    assign out_tag   = head.tag;
`ifdef ALU_RESULT_PARITY_EN
    assign out_parity = head.parity;
`endif
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DATA_W, default 8: width of ALU result word.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, >=2.
REQ-003 Parameter TAG_W, default 4: width of packet sequence tag.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  ALU result strobe, driven from ALU valid_out.
REQ-007 in_alu  input  DATA_W  ALU result.
REQ-008 in_carry  input  1  ALU carry flag.
REQ-009 in_zero  input  1  ALU zero flag.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  consumer accepts head entry.
REQ-012 out_alu / out_carry / out_zero  output  DATA_W/1/1  head entry fields.
REQ-013 out_tag  output  TAG_W  sequence tag of head entry.
REQ-014 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 full / empty  output  1  count==DEPTH / count==0.
REQ-016 overflow  output  1  sticky: at least one result dropped.
REQ-017 clr_ovf  input  1  clears overflow.

Function
REQ-018 Block SHALL be the stage directly downstream of the ALU; no backpressure to ALU exists, so results arriving when no slot is free are dropped.
REQ-019 Push = in_valid && (!full || pop); pop = out_valid && out_ready.
REQ-020 Storage SHALL be a circular buffer with write/read pointers wrapping modulo DEPTH.
REQ-021 Output SHALL be first-word-fall-through: out_* driven from the head entry, out_valid = !empty.
REQ-022 Latency: entry pushed at edge N SHALL appear with out_valid=1 after edge N (visible in cycle N+1); no same-cycle bypass when empty.
REQ-023 Simultaneous push and pop: count unchanged; allowed when full (slot freed by pop is reused).
REQ-024 Push when empty with out_ready=1: no pop that cycle; entry presented next cycle.
REQ-025 Tag counter SHALL increment (wrap at 2^TAG_W) on every cycle in_valid=1, including dropped results; each accepted entry stores the counter value before increment.
REQ-026 Dropped result (in_valid && full && !pop) SHALL set overflow next edge; entry contents unchanged.
REQ-027 clr_ovf=1 clears overflow; if a drop occurs the same cycle, set wins.
REQ-028 out_ready with empty buffer SHALL have no effect; pointers never underflow.
REQ-029 out_* SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-030 reset=1 at an edge SHALL zero pointers, count, tag counter, overflow; empty=1, full=0, out_valid=0.
REQ-031 Reset mid-operation SHALL discard all stored entries; in_valid and out_ready ignored during reset cycle.
REQ-032 Storage array contents need not be reset; out_alu/out_carry/out_zero/out_tag are don't-care while out_valid=0.

Configuration
REQ-033 Macro ALU_RESULT_PARITY_EN defined: each entry stores even parity bit = XOR of {in_alu,in_carry,in_zero} computed at push; extra output port out_parity (1 bit) driven from head entry.
REQ-034 ALU_RESULT_PARITY_EN undefined: no parity storage, no out_parity port; all other behaviour identical.

Verification
REQ-035 Reset then 3 pushes (alu=8'h11,8'h22,8'h33), out_ready=0 -> count=3, out_alu=8'h11, out_tag=0; then out_ready=1 for 3 cycles -> 11,22,33 with tags 0,1,2, empty=1.
REQ-036 Fill 8 entries, push 9th (alu=8'hAA) with out_ready=0 -> full=1, overflow=1, 8'hAA absent; next accepted push carries tag 9.
REQ-037 Full buffer, push 8'h55 with out_ready=1 same cycle -> count stays 8, overflow stays 0, 8'h55 at tail.
REQ-038 Push 17 results with continuous out_ready=1 -> tags 0..15,0 (wrap), no loss, count never exceeds 1.
REQ-039 overflow=1, assert clr_ovf with simultaneous drop -> overflow=1; clr_ovf alone next cycle -> overflow=0.
REQ-040 Buffer holding 5 entries, reset=1 one cycle with in_valid=1 -> count=0, empty=1, overflow=0, next push tag=0; with ALU_RESULT_PARITY_EN, push alu=8'h07,carry=1,zero=0 -> out_parity=0.
